// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table equivalence checker.
package truth_table_pkg;

    localparam int unsigned TT_N_IN_DEF   = 2;
    localparam int unsigned TT_SETTLE_DEF = 1;

    typedef enum logic [1:0] {
        TT_IDLE    = 2'd0,
        TT_SETTLE  = 2'd1,
        TT_COMPARE = 2'd2,
        TT_DONE    = 2'd3
    } tt_state_e;

    // Cycle (1-based, counted from the edge sampling start) in which done is high.
    function automatic int unsigned tt_latency(input int unsigned n_in, input int unsigned settle);
        return ((32'd1 << n_in) * (settle + 32'd1)) + 32'd1;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the checker and the logic pair under test.
// Optional mismatch_map signal is present only when TT_MISMATCH_MAP_EN is defined.
interface truth_table_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            s_orig;
    logic            s_simp;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err;
    logic            first_err_vld;
`ifdef TT_MISMATCH_MAP_EN
    logic [(1<<N_IN)-1:0] mismatch_map;
`endif

    modport master (
`ifdef TT_MISMATCH_MAP_EN
        output mismatch_map,
`endif
        input  start, s_orig, s_simp,
        output stim, busy, done, pass, err_count, first_err, first_err_vld
    );

    modport slave (
`ifdef TT_MISMATCH_MAP_EN
        input  mismatch_map,
`endif
        output start, s_orig, s_simp,
        input  stim, busy, done, pass, err_count, first_err, first_err_vld
    );
endinterface

// File: rtl/tt_stim_counter.sv
// Vector counter and per-vector settle counter driving the stimulus.
module tt_stim_counter #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            settle_en,
    input  logic            adv,
    output logic [N_IN-1:0] stim,
    output logic            last_vec,
    output logic            settle_hit
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim <= '0;
            cnt  <= '0;
        end else if (clr) begin
            stim <= '0;
            cnt  <= '0;
        end else if (adv) begin
            stim <= stim + N_IN'(1);
            cnt  <= '0;
        end else if (settle_en && !settle_hit) begin
            cnt  <= cnt + CW'(1);
        end
    end

    assign last_vec   = &stim;
    assign settle_hit = (cnt == CNT_MAX);
endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors of a logic pair and reports whether both outputs agree.
// Define TT_MISMATCH_MAP_EN to add a per-vector mismatch bitmap output.
module truth_table_checker
    import truth_table_pkg::*;
#(
    parameter int unsigned N_IN   = TT_N_IN_DEF,
    parameter int unsigned SETTLE = TT_SETTLE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    truth_table_checker_if.master        bus
);
    localparam int unsigned EW = N_IN + 1;
    localparam int unsigned VN = 1 << N_IN;

    tt_state_e       state, state_nxt;
    logic [N_IN-1:0] stim;
    logic            last_vec, settle_hit;
    logic            clr_c, settle_en_c, adv_c, mismatch_c;

    logic            busy, busy_d, done, done_d, pass, pass_d, fvld, fvld_d;
    logic [EW-1:0]   err, err_d;
    logic [N_IN-1:0] ferr, ferr_d;
    logic [VN-1:0]   map, map_d;

    tt_stim_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_c),
        .settle_en  (settle_en_c),
        .adv        (adv_c),
        .stim       (stim),
        .last_vec   (last_vec),
        .settle_hit (settle_hit)
    );

    // Case inequality so that X/Z from the logic under test is flagged.
    assign mismatch_c  = (bus.s_orig !== bus.s_simp);
    assign clr_c       = (state == TT_IDLE) && bus.start;
    assign settle_en_c = (state == TT_SETTLE);
    assign adv_c       = (state == TT_COMPARE) && !last_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TT_IDLE:    if (bus.start)  state_nxt = TT_SETTLE;
            TT_SETTLE:  if (settle_hit) state_nxt = TT_COMPARE;
            TT_COMPARE: state_nxt = last_vec ? TT_DONE : TT_SETTLE;
            TT_DONE:    state_nxt = TT_IDLE;
            default:    state_nxt = TT_IDLE;
        endcase
    end

    // Next values of the registered result outputs.
    always_comb begin
        busy_d = busy;
        done_d = 1'b0;
        pass_d = pass;
        err_d  = err;
        ferr_d = ferr;
        fvld_d = fvld;
        map_d  = map;
        case (state)
            TT_IDLE: if (bus.start) begin
                busy_d = 1'b1;
                pass_d = 1'b0;
                err_d  = '0;
                ferr_d = '0;
                fvld_d = 1'b0;
                map_d  = '0;
            end
            TT_COMPARE: begin
                if (mismatch_c) begin
                    err_d       = err + EW'(1);
                    map_d[stim] = 1'b1;
                    if (!fvld) begin
                        ferr_d = stim;
                        fvld_d = 1'b1;
                    end
                end
                if (last_vec) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err  <= '0;
            ferr <= '0;
            fvld <= 1'b0;
            map  <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            pass <= pass_d;
            err  <= err_d;
            ferr <= ferr_d;
            fvld <= fvld_d;
            map  <= map_d;
        end
    end

    assign bus.stim          = stim;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.err_count     = err;
    assign bus.first_err     = ferr;
    assign bus.first_err_vld = fvld;
`ifdef TT_MISMATCH_MAP_EN
    assign bus.mismatch_map  = map;
`else
    logic unused_map;
    assign unused_map = ^map;
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=3)
// driven by truth tables held in the bench and checked against a sweep model.
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    logic xm;
    logic xval;
    logic [3:0] orig_tt, simp_tt;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(2)) b1 ();
    truth_table_checker_if #(.N_IN(2)) b3 ();

    truth_table_checker #(.N_IN(2), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    truth_table_checker #(.N_IN(2), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    // The logic pair under test, as lookup tables indexed by the stimulus.
    always_comb begin
        b1.start  = start & ~sel;
        b3.start  = start & sel;
        b1.s_orig = xm ? xval : orig_tt[b1.stim];
        b1.s_simp = simp_tt[b1.stim];
        b3.s_orig = xm ? xval : orig_tt[b3.stim];
        b3.s_simp = simp_tt[b3.stim];
    end

    logic       o_busy, o_done, o_pass, o_fvld;
    logic [2:0] o_err;
    logic [1:0] o_ferr, o_stim;
    logic [3:0] o_map;
    always_comb begin
        o_busy = sel ? b3.busy          : b1.busy;
        o_done = sel ? b3.done          : b1.done;
        o_pass = sel ? b3.pass          : b1.pass;
        o_fvld = sel ? b3.first_err_vld : b1.first_err_vld;
        o_err  = sel ? b3.err_count     : b1.err_count;
        o_ferr = sel ? b3.first_err     : b1.first_err;
        o_stim = sel ? b3.stim          : b1.stim;
`ifdef TT_MISMATCH_MAP_EN
        o_map  = sel ? b3.mismatch_map  : b1.mismatch_map;
`else
        o_map  = 4'd0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk every vector and tally where the two tables disagree.
    task automatic model(output int ec, output int fe, output bit fv, output logic [3:0] mm);
        logic o;
        ec = 0; fe = 0; fv = 1'b0; mm = 4'd0;
        for (int i = 0; i < 4; i++) begin
            o = xm ? xval : orig_tt[i];
            if (o !== simp_tt[i]) begin
                ec++;
                mm[i] = 1'b1;
                if (!fv) begin
                    fe = i;
                    fv = 1'b1;
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 32'(o_busy), 0);
        check({tag, ".done"}, 32'(o_done), 0);
        check({tag, ".pass"}, 32'(o_pass), 0);
        check({tag, ".err"},  32'(o_err),  0);
        check({tag, ".ferr"}, 32'(o_ferr), 0);
        check({tag, ".fvld"}, 32'(o_fvld), 0);
        check({tag, ".stim"}, 32'(o_stim), 0);
        check({tag, ".map"},  32'(o_map),  0);
    endtask

    task automatic run(input bit s, input int start_at, input int rst_at, input string tag);
        int lat, c, ec, fe;
        bit fv;
        logic [3:0] mm;
        sel = s;
        lat = 4 * ((s ? 3 : 1) + 1) + 1;
        model(ec, fe, fv, mm);
        @(negedge clk);
        start = 1'b1;
        for (c = 1; c <= lat + 5; c++) begin
            @(negedge clk);
            if (c == start_at)          start = 1'b1;
            else if (c == start_at + 1 || c == 1) start = 1'b0;
            if (c == 1) check({tag, ".busy_rise"}, 32'(o_busy), 1);
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero({tag, ".rst"});
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (o_done) break;
        end
        check({tag, ".lat"},  32'(c),      32'(lat));
        check({tag, ".busy"}, 32'(o_busy), 0);
        check({tag, ".err"},  32'(o_err),  32'(ec));
        check({tag, ".fvld"}, 32'(o_fvld), 32'(fv));
        check({tag, ".ferr"}, 32'(o_ferr), 32'(fe));
        check({tag, ".pass"}, 32'(o_pass), 32'(ec == 0));
        check({tag, ".stim"}, 32'(o_stim), 3);
`ifdef TT_MISMATCH_MAP_EN
        check({tag, ".map"},  32'(o_map),  32'(mm));
`endif
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(o_done), 0);
        check({tag, ".pass_hold"},  32'(o_pass), 32'(ec == 0));
        check({tag, ".err_hold"},   32'(o_err),  32'(ec));
    endtask

    initial begin
        xval    = 1'bx;
        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        xm      = 1'b0;
        orig_tt = 4'b0100;
        simp_tt = 4'b0100;
        repeat (2) @(negedge clk);
        check_zero("reset1");
        sel = 1'b1;
        #1 check_zero("reset3");
        @(negedge clk);
        rst_n = 1'b1;

        simp_tt = 4'b0100; run(1'b0, 0, 0, "ident");
        simp_tt = 4'b0000; run(1'b0, 0, 0, "single");
        simp_tt = 4'b1011; run(1'b0, 0, 0, "total");
        xm = 1'b1; simp_tt = 4'b0100; run(1'b0, 0, 0, "xin"); xm = 1'b0;
        simp_tt = 4'b0000; run(1'b0, 4, 0, "busy_start");
        simp_tt = 4'b1011; run(1'b0, 0, 5, "rst_mid");
        simp_tt = 4'b0100; run(1'b1, 0, 0, "settle3");

        for (int k = 0; k < 10; k++) begin
            orig_tt = 4'($urandom);
            simp_tt = ($urandom_range(0, 2) == 0) ? orig_tt : 4'($urandom);
            xm      = ($urandom_range(0, 5) == 0);
            run(1'($urandom_range(0, 1)), 0, 0, $sformatf("rand%0d", k));
        end
        xm = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
